// File: rtl/fetch_pkg.sv
// Shared processor constants: fetch FSM encoding, reset PC and the NOP word.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_VALID  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [15:0] PC_STEP   = 16'd2;

    // Instructions are halfword aligned; bit 0 of any target is ignored.
    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel between fetch and memory.
interface fetch_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;

    modport master (output imem_req, imem_addr, input imem_ack, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/pc_reg.sv
// 16-bit program counter with load enable and synchronous reset.
module pc_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] d,
    output logic [15:0] q
);

    // PC register: reset to the architectural start address, load on demand.
    always_ff @(posedge clk) begin
        if (rst)       q <= RESET_PC;
        else if (load) q <= d;
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: one outstanding request, holds the word for decode,
// squashes in-flight responses on redirect and stops on HALT.
//
// state     | meaning
// ST_REQ    | request outstanding at PC
// ST_VALID  | instruction held for decode
// ST_DRAIN  | waiting to discard a squashed response
// ST_HALTED | stopped by HALT, only rst exits
module fetch
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fetch_if.master       mem,
    input  logic          stall,
    input  logic          redirect,
    input  logic [15:0]   redirect_pc,
    input  logic          halt,
    output logic [15:0]   instr,
    output logic [15:0]   PC_Next,
    output logic          instr_valid,
    output logic          halted,
    output logic          err
);

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d, pc_inc;
    logic         pc_load, capture, err_set;

    assign pc_inc = pc_q + PC_STEP;

    pc_reg u_pc (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .d    (pc_d),
        .q    (pc_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_REQ;
        else     state_q <= state_d;
    end

    // Next state, PC update and error detection; redirect beats stall/halt.
    always_comb begin
        state_d = state_q;
        pc_load = 1'b0;
        pc_d    = pc_inc;
        capture = 1'b0;
        err_set = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (redirect) begin
                    pc_load = 1'b1;
                    pc_d    = align_pc(redirect_pc);
                    // A response arriving with the redirect is simply dropped.
                    state_d = mem.imem_ack ? ST_REQ : ST_DRAIN;
                end else if (mem.imem_ack) begin
                    capture = 1'b1;
                    pc_load = 1'b1;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (mem.imem_ack) err_set = 1'b1;
                if (redirect) begin
                    pc_load = 1'b1;
                    pc_d    = align_pc(redirect_pc);
                    state_d = ST_REQ;
                end else if (!stall) begin
                    state_d = halt ? ST_HALTED : ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    pc_load = 1'b1;
                    pc_d    = align_pc(redirect_pc);
                end
                // The squashed response retires the old request; waiting
                // for another ack would never finish.
                if (mem.imem_ack) state_d = ST_REQ;
            end
            ST_HALTED: begin
                if (mem.imem_ack) err_set = 1'b1;
            end
            default: state_d = ST_REQ;
        endcase
        if (redirect && redirect_pc[0] && state_q != ST_HALTED) err_set = 1'b1;
    end

    // Registered decode-facing word, its successor address and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr   <= NOP_INSTR;
            PC_Next <= RESET_PC;
            err     <= 1'b0;
        end else begin
            if (capture) begin
                instr   <= mem.imem_data;
                PC_Next <= pc_inc;
            end
            if (err_set) err <= 1'b1;
        end
    end

    assign mem.imem_req  = (state_q == ST_REQ);
    assign mem.imem_addr = pc_q;
    assign instr_valid   = (state_q == ST_VALID);
    assign halted        = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios with literal expectations, then random
// traffic against a behavioural model of the fetch rules.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, halt;
    logic [15:0] redirect_pc;
    logic [15:0] instr, PC_Next;
    logic        instr_valid, halted, err;

    always #5 clk = ~clk;

    fetch_if bus ();

    fetch dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .instr       (instr),
        .PC_Next     (PC_Next),
        .instr_valid (instr_valid),
        .halted      (halted),
        .err         (err)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: "holding" = a word is presented, "squash" = one response owed
    // that must be thrown away.
    logic [15:0] m_pc, m_instr, m_pcn;
    logic        m_holding, m_halted, m_squash, m_err;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("imem_req",    16'(bus.imem_req), 16'(!m_holding && !m_halted && !m_squash));
        chk("imem_addr",   bus.imem_addr, m_pc);
        chk("instr",       instr, m_instr);
        chk("PC_Next",     PC_Next, m_pcn);
        chk("instr_valid", 16'(instr_valid), 16'(m_holding));
        chk("halted",      16'(halted), 16'(m_halted));
        chk("err",         16'(err), 16'(m_err));
    endtask

    task automatic model_update(input logic r, st, hl, rd, input logic [15:0] rpc,
                                input logic a, input logic [15:0] d);
        if (r) begin
            m_pc = 16'h0000; m_instr = 16'h0800; m_pcn = 16'h0000;
            m_holding = 0; m_halted = 0; m_squash = 0; m_err = 0;
        end else if (m_halted) begin
            if (a) m_err = 1;
        end else begin
            if (rd && rpc[0]) m_err = 1;
            if (m_holding && a) m_err = 1;
            if (rd) begin
                m_pc = rpc & 16'hFFFE;
                if (m_holding)            m_holding = 0;
                else if (!m_squash && !a) m_squash = 1;
                else if (m_squash && a)   m_squash = 0;
            end else if (m_holding) begin
                if (!st) begin
                    m_holding = 0;
                    m_halted  = hl;
                end
            end else if (m_squash) begin
                if (a) m_squash = 0;
            end else if (a) begin
                m_instr   = d;
                m_pcn     = m_pc + 16'd2;
                m_pc      = m_pcn;
                m_holding = 1;
            end
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), advance the model,
    // then compare everything at the next falling edge.
    task automatic step(input logic r, st, hl, rd, input logic [15:0] rpc,
                        input logic a, input logic [15:0] d);
        rst = r; stall = st; halt = hl; redirect = rd; redirect_pc = rpc;
        bus.imem_ack = a; bus.imem_data = d;
        model_update(r, st, hl, rd, rpc, a, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
    endtask

    initial begin
        int  dly;
        bit  pend;
        rst = 1; stall = 0; halt = 0; redirect = 0; redirect_pc = 0;
        bus.imem_ack = 0; bus.imem_data = 0;
        @(negedge clk);

        // Reset values
        step(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
        step(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("rst_instr", instr, 16'h0800);
        chk("rst_pcnext", PC_Next, 16'h0000);
        chk("rst_valid", 16'(instr_valid), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        idle();
        chk("first_req", 16'(bus.imem_req), 16'h1);
        chk("first_addr", bus.imem_addr, 16'h0000);

        // Zero-wait ack
        step(0, 0, 0, 0, 16'h0000, 1, 16'h4001);
        chk("ack_instr", instr, 16'h4001);
        chk("ack_pcnext", PC_Next, 16'h0002);
        chk("ack_valid", 16'(instr_valid), 16'h1);

        // Stall for three cycles
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 16'h0000, 0, 16'h0000);
            chk("stall_instr", instr, 16'h4001);
            chk("stall_pcnext", PC_Next, 16'h0002);
            chk("stall_valid", 16'(instr_valid), 16'h1);
            chk("stall_noreq", 16'(bus.imem_req), 16'h0);
        end
        idle();
        chk("next_req", 16'(bus.imem_req), 16'h1);
        chk("next_addr", bus.imem_addr, 16'h0002);

        // Redirect while waiting, late ack dropped
        idle();
        step(0, 0, 0, 1, 16'h0100, 0, 16'h0000);
        chk("drain_noreq", 16'(bus.imem_req), 16'h0);
        step(0, 0, 0, 0, 16'h0000, 1, 16'hBEEF);
        chk("drain_valid", 16'(instr_valid), 16'h0);
        chk("drain_addr", bus.imem_addr, 16'h0100);
        chk("drain_req", 16'(bus.imem_req), 16'h1);
        step(0, 0, 0, 0, 16'h0000, 1, 16'h1234);
        chk("redir_instr", instr, 16'h1234);
        chk("redir_pcnext", PC_Next, 16'h0102);

        // Halt
        step(0, 0, 1, 0, 16'h0000, 0, 16'h0000);
        chk("halted", 16'(halted), 16'h1);
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("halt_noreq", 16'(bus.imem_req), 16'h0);
        end
        step(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
        idle();
        chk("restart_req", 16'(bus.imem_req), 16'h1);
        chk("restart_addr", bus.imem_addr, 16'h0000);
        chk("restart_halted", 16'(halted), 16'h0);

        // Wrap at 0xFFFE
        step(0, 0, 0, 1, 16'hFFFE, 0, 16'h0000);
        step(0, 0, 0, 0, 16'h0000, 1, 16'h0000);
        chk("wrap_addr_pre", bus.imem_addr, 16'hFFFE);
        step(0, 0, 0, 0, 16'h0000, 1, 16'h1111);
        chk("wrap_pcnext", PC_Next, 16'h0000);
        chk("wrap_err", 16'(err), 16'h0);
        idle();
        chk("wrap_addr", bus.imem_addr, 16'h0000);

        // Odd redirect target
        step(0, 0, 0, 1, 16'h0011, 0, 16'h0000);
        chk("odd_err", 16'(err), 16'h1);
        step(0, 0, 0, 0, 16'h0000, 1, 16'h0000);
        chk("odd_addr", bus.imem_addr, 16'h0010);
        step(0, 0, 0, 0, 16'h0000, 1, 16'h2222);
        chk("odd_pcnext", PC_Next, 16'h0012);
        chk("odd_err_held", 16'(err), 16'h1);

        // Spurious ack while holding
        step(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("err_cleared", 16'(err), 16'h0);
        step(0, 0, 0, 0, 16'h0000, 1, 16'h3333);
        step(0, 1, 0, 0, 16'h0000, 1, 16'h5555);
        chk("spur_err", 16'(err), 16'h1);
        chk("spur_instr", instr, 16'h3333);
        step(0, 1, 0, 0, 16'h0000, 0, 16'h0000);
        chk("spur_err_held", 16'(err), 16'h1);

        // Random traffic
        step(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
        pend = 0;
        dly  = 0;
        for (int i = 0; i < 4000; i++) begin
            logic        a, r, st, hl, rd;
            logic [15:0] d, rpc;
            a = 0;
            d = 16'($urandom);
            if (pend) begin
                if (dly == 0) begin
                    a = 1; pend = 0;
                end else dly--;
            end else if (bus.imem_req) begin
                dly = $urandom_range(0, 3);
                if (dly == 0) a = 1;
                else begin
                    pend = 1; dly--;
                end
            end else if ($urandom_range(0, 149) == 0) begin
                a = 1;
            end
            r  = ($urandom_range(0, 299) == 0) || (m_halted && $urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 2) == 0);
            hl = ($urandom_range(0, 9) == 0);
            rd = !m_halted && !(m_squash && a) && ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 15))
                0:       rpc = 16'hFFFE;
                1:       rpc = 16'($urandom) | 16'h0001;
                default: rpc = 16'($urandom) & 16'hFFFE;
            endcase
            step(r, st, hl, rd, rpc, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
